// File: rtl/speed_tx_if.sv
// rtl/speed_tx_if.sv - word write handshake between a producer and speed_tx
// Signals:
//   wr_data  [3:0] speed word to transmit
//   wr_valid       wr_data holds a word
//   wr_ready       transmitter FIFO can take a word this edge
// Modports: master = producer, slave = speed_tx.
interface speed_tx_if;
  logic [3:0] wr_data;
  logic       wr_valid;
  logic       wr_ready;

  modport master (output wr_data, output wr_valid, input wr_ready);
  modport slave  (input wr_data, input wr_valid, output wr_ready);
endinterface

// File: rtl/speed_tx.sv
// rtl/speed_tx.sv - 4-bit speed word serialiser with strobe/data pair and word FIFO
// Purpose: queues speed words and sends each MSB first as four strobe pulses.
//   freq is set up one strobe phase before each f_en rise and held through HIGH;
//   a GAP-cycle idle spacer follows each word.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   en           link enable, gates only the start of a new word
//   wr           word write handshake (slave side)
//   f_en, freq   serial strobe and data
//   busy         transmitter is not idle
//   level        FIFO occupancy 0..DEPTH
module speed_tx #(
  parameter int DIV   = 8,
  parameter int GAP   = 16,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  speed_tx_if.slave              wr,
  output logic                   f_en,
  output logic                   freq,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [7:0] DIV_M1 = 8'(DIV - 1);
  localparam logic [7:0] GAP_M1 = (GAP > 0) ? 8'(GAP - 1) : 8'd0;

  typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_HIGH, ST_GAP} state_t;

  state_t        state_q, state_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [3:0]    sh_q, sh_d;
  logic          f_en_q, f_en_d;
  logic          freq_q, freq_d;

  logic [3:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          full, push, pop;

  assign full        = (level_q == LW'(DEPTH));
  assign wr.wr_ready = !full && !rst;
  assign push        = wr.wr_valid && wr.wr_ready;

  // Pop is decided from the registered level, so a word written into an
  // empty FIFO only becomes visible to IDLE on the following edge.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    sh_d    = sh_q;
    f_en_d  = f_en_q;
    freq_d  = freq_q;
    pop     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        f_en_d = 1'b0;
        freq_d = 1'b0;
        if (en && (level_q != '0)) begin
          pop     = 1'b1;
          sh_d    = mem_q[rd_ptr_q];
          idx_d   = 2'd3;
          freq_d  = mem_q[rd_ptr_q][3];
          cnt_d   = DIV_M1;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (cnt_q == 8'd0) begin
          f_en_d  = 1'b1;
          cnt_d   = DIV_M1;
          state_d = ST_HIGH;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ST_HIGH: begin
        if (cnt_q == 8'd0) begin
          f_en_d = 1'b0;
          if (idx_q != 2'd0) begin
            // Next bit goes out together with the strobe fall, giving it a
            // full SETUP phase before the next rise.
            idx_d   = idx_q - 2'd1;
            freq_d  = sh_q[idx_q - 2'd1];
            cnt_d   = DIV_M1;
            state_d = ST_SETUP;
          end else begin
            freq_d = 1'b0;
            if (GAP == 0) begin
              cnt_d   = 8'd0;
              state_d = ST_IDLE;
            end else begin
              cnt_d   = GAP_M1;
              state_d = ST_GAP;
            end
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ST_GAP: begin
        if (cnt_q == 8'd0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 8'd0;
      idx_q    <= 2'd0;
      sh_q     <= 4'd0;
      f_en_q   <= 1'b0;
      freq_q   <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      sh_q     <= sh_d;
      f_en_q   <= f_en_d;
      freq_q   <= freq_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage needs no reset: level and pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr.wr_data;
    end
  end

  assign f_en  = f_en_q;
  assign freq  = freq_q;
  assign busy  = (state_q != ST_IDLE);
  assign level = level_q;

endmodule

// File: doc/speed_tx.md
SPEED_TX -- requirements
Module: speed_tx

Interface
REQ-001 Parameter DIV, default 8: clk cycles per strobe phase; legal range 1..255.
REQ-002 Parameter GAP, default 16: idle clk cycles inserted after each 4-bit word; legal range 0..255.
REQ-003 Parameter DEPTH, default 4: word FIFO depth; power of two, at least 2.
REQ-004 clk  input  1  system clock; all state changes on its rising edge.
REQ-005 rst  input  1  reset; synchronous, active-high.
REQ-006 en  input  1  link enable, shared with the speed receiver; gates the start of new words.
REQ-007 wr_data  input  4  speed word to transmit.
REQ-008 wr_valid  input  1  wr_data is valid.
REQ-009 wr_ready  output  1  FIFO can accept a word; equals !full && !rst.
REQ-010 f_en  output  1  serial strobe; the receiver samples on its rising edge.
REQ-011 freq  output  1  serial data, MSB first.
REQ-012 busy  output  1  high in any state other than IDLE.
REQ-013 level  output  log2(DEPTH)+1  current FIFO occupancy, 0..DEPTH.

Function
REQ-014 A word shall be written into the FIFO on each clk edge where wr_valid && wr_ready.
REQ-015 When full (level == DEPTH), wr_ready shall be 0; wr_data shall be ignored, with no overwrite and no level change.
REQ-016 A push and a pop on the same edge shall leave level unchanged; the FIFO shall preserve word order.
REQ-017 A word pushed into an empty FIFO shall not be popped on the same edge; it becomes poppable one edge later.
REQ-018 The FSM shall have the states IDLE, SETUP, HIGH and GAP, all registered.
REQ-019 IDLE: on an edge with en == 1 and level > 0, the FSM shall pop the head word into a 4-bit shift register, set bit index = 3, drive freq <= word[3], and go to SETUP.
REQ-020 IDLE with en == 0 or level == 0: the FSM shall hold, with f_en = 0 and freq = 0.
REQ-021 SETUP shall last exactly DIV cycles with f_en = 0 and freq stable, then go to HIGH, driving f_en <= 1.
REQ-022 HIGH shall last exactly DIV cycles with f_en = 1 and freq stable.
REQ-023 At the end of HIGH with bit index > 0, the FSM shall decrement the index, drive f_en <= 0 and freq <= next bit, and go to SETUP.
REQ-024 At the end of HIGH with bit index == 0, the FSM shall drive f_en <= 0 and freq <= 0 and go to GAP.
REQ-025 GAP shall last exactly GAP cycles with f_en = 0 and freq = 0, then go to IDLE; with GAP = 0 it shall go directly to IDLE.
REQ-026 freq shall never change on the same edge on which f_en rises, and shall never change while f_en = 1.
REQ-027 One word shall occupy exactly 8*DIV + GAP cycles from leaving IDLE to re-entering IDLE.
REQ-028 Back-to-back words shall each incur one IDLE cycle; the period per word is 8*DIV + GAP + 1 cycles.
REQ-029 Latency: the first f_en rise of a word pushed into an empty, idle FIFO with en = 1 shall occur on the (DIV+1)th clk edge after the accepting edge.
REQ-030 en deasserted mid-word shall not truncate the word; the word shall complete, including GAP, and no further word shall start until en == 1.
REQ-031 Every word shall produce exactly 4 f_en rising edges, so the receiver's 4-edge framing stays aligned.
REQ-032 Phase counters shall be 8 bits wide, shall not wrap, and shall be reloaded on each state entry.

Reset
REQ-033 While rst = 1 at an edge: FSM <= IDLE, f_en <= 0, freq <= 0, busy <= 0, FIFO cleared (level <= 0), shift register and counters <= 0.
REQ-034 rst asserted mid-word shall abort the word immediately and produce no further f_en edges; queued words are discarded.
REQ-035 wr_ready shall be 0 while rst = 1 and shall be 1 on the first cycle after rst deasserts.

Verification (DIV=2, GAP=4, DEPTH=4)
REQ-036 Push 4'b1010 at edge 0 with en=1 -> f_en rises at edges 3, 7, 11, 15; freq is 1, 0, 1, 0 at those rises; busy drops at edge 21.
REQ-037 Push 4'hF, 4'h0, 4'h9 back-to-back -> three frames 21 cycles apart; sampled words F, 0, 9; level peaks at 2.
REQ-038 Push 5 words while en=0 -> level=4 and wr_ready=0; the 5th word is dropped; after en=1, exactly 4 frames are sent, with 16 f_en rises in total.
REQ-039 Drop en during the 2nd bit of 4'h6 -> frame completes with value 6; the next queued word is not sent until en returns.
REQ-040 Assert rst for 1 cycle during HIGH of bit 2 -> f_en=0 and freq=0 the next cycle, level=0, no further rises; a new push afterwards transmits correctly.
REQ-041 Loopback into the existing speed receiver with random words and random en gaps -> received speed equals each transmitted word, in order.
